// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - registered request/acknowledge memory port shared by fetch and data
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              m_req_o;
    logic              m_we_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_wdata_o;
    logic [DATA_W-1:0] m_rdata_i;
    logic              m_ack_i;

    modport master (
        output m_req_o,
        output m_we_o,
        output m_addr_o,
        output m_wdata_o,
        input  m_rdata_i,
        input  m_ack_i
    );

    modport slave (
        input  m_req_o,
        input  m_we_o,
        input  m_addr_o,
        input  m_wdata_o,
        output m_rdata_i,
        output m_ack_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one memory port with flush and watchdog
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    output logic              if_stall_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_done_o,
    output logic              d_stall_o,
    input  logic              flush_i,
    output logic              err_o,
    mem_port_arbiter_if.master mem
);
    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_D  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_d_q, last_grant_d_d;
    logic              discard_q, discard_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_done_q, if_done_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_done_q, d_done_d;

    logic              if_elig, d_elig, grant_d;
    logic              timeout, finish;
    logic [DATA_W-1:0] ret_data;

    // A port whose done pulse is high is not re-granted in the same cycle.
    assign if_elig  = if_req_i & ~if_done_q & ~flush_i;
    assign d_elig   = d_req_i & ~d_done_q;
    assign grant_d  = d_elig & (~if_elig | ~last_grant_d_q);
    assign timeout  = ~mem.m_ack_i & (wait_q == WAIT_LAST);
    assign finish   = mem.m_ack_i | timeout;
    assign ret_data = mem.m_ack_i ? mem.m_rdata_i : '0;

    always_comb begin
        state_d        = state_q;
        last_grant_d_d = last_grant_d_q;
        discard_d      = discard_q;
        wait_d         = wait_q;
        err_d          = err_q;
        m_req_d        = m_req_q;
        m_we_d         = m_we_q;
        m_addr_d       = m_addr_q;
        m_wdata_d      = m_wdata_q;
        if_rdata_d     = if_rdata_q;
        if_done_d      = 1'b0;
        d_rdata_d      = d_rdata_q;
        d_done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_elig || d_elig) begin
                    m_req_d   = 1'b1;
                    wait_d    = '0;
                    discard_d = 1'b0;
                    if (grant_d) begin
                        state_d        = S_BUSY_D;
                        last_grant_d_d = 1'b1;
                        m_we_d         = d_we_i;
                        m_addr_d       = d_addr_i;
                        m_wdata_d      = d_wdata_i;
                    end else begin
                        state_d        = S_BUSY_IF;
                        last_grant_d_d = 1'b0;
                        m_we_d         = 1'b0;
                        m_addr_d       = if_addr_i;
                        m_wdata_d      = '0;
                    end
                end
            end
            S_BUSY_IF, S_BUSY_D: begin
                if (finish) begin
                    state_d = S_IDLE;
                    m_req_d = 1'b0;
                    wait_d  = '0;
                    if (timeout) begin
                        err_d = 1'b1;
                    end
                    // A fetch flushed at any point up to its completion is dropped silently.
                    if (state_q == S_BUSY_IF) begin
                        if (discard_q || flush_i) begin
                            discard_d = 1'b0;
                        end else begin
                            if_done_d  = 1'b1;
                            if_rdata_d = ret_data;
                        end
                    end else begin
                        d_done_d = 1'b1;
                        if (!m_we_q || timeout) begin
                            d_rdata_d = ret_data;
                        end
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (state_q == S_BUSY_IF && flush_i) begin
                        discard_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            last_grant_d_q <= 1'b0;
            discard_q      <= 1'b0;
            wait_q         <= '0;
            err_q          <= 1'b0;
            m_req_q        <= 1'b0;
            m_we_q         <= 1'b0;
            m_addr_q       <= '0;
            m_wdata_q      <= '0;
            if_rdata_q     <= '0;
            if_done_q      <= 1'b0;
            d_rdata_q      <= '0;
            d_done_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_d_q <= last_grant_d_d;
            discard_q      <= discard_d;
            wait_q         <= wait_d;
            err_q          <= err_d;
            m_req_q        <= m_req_d;
            m_we_q         <= m_we_d;
            m_addr_q       <= m_addr_d;
            m_wdata_q      <= m_wdata_d;
            if_rdata_q     <= if_rdata_d;
            if_done_q      <= if_done_d;
            d_rdata_q      <= d_rdata_d;
            d_done_q       <= d_done_d;
        end
    end

    assign mem.m_req_o   = m_req_q;
    assign mem.m_we_o    = m_we_q;
    assign mem.m_addr_o  = m_addr_q;
    assign mem.m_wdata_o = m_wdata_q;
    assign if_rdata_o    = if_rdata_q;
    assign if_done_o     = if_done_q;
    assign d_rdata_o     = d_rdata_q;
    assign d_done_o      = d_done_q;
    assign err_o         = err_q;
    assign if_stall_o    = if_req_i & ~if_done_q & ~rst_i;
    assign d_stall_o     = d_req_i & ~d_done_q & ~rst_i;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done, if_stall;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [31:0] d_rdata;
    logic        d_done, d_stall;
    logic        flush;
    logic        err;
    int          checks = 0;
    int          errors = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
        .if_done_o(if_done), .if_stall_o(if_stall),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata), .d_done_o(d_done), .d_stall_o(d_stall),
        .flush_i(flush), .err_o(err), .mem(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; flush = 1'b0;
        if_addr = 32'h0000_1000; d_addr = 32'h0000_2000; d_wdata = 32'h0;
        bus.m_ack_i = 1'b0; bus.m_rdata_i = 32'h0;
        step(); step(); #1;
        checks++; if (bus.m_req_o !== 1'b0) begin errors++; $display("FAIL rst_m_req got %0h exp 0", bus.m_req_o); end
        checks++; if ({bus.m_we_o, bus.m_addr_o, bus.m_wdata_o} !== 65'h0) begin errors++; $display("FAIL rst_m_bus got %0h/%0h/%0h exp 0", bus.m_we_o, bus.m_addr_o, bus.m_wdata_o); end
        checks++; if ({if_done, d_done, err} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {if_done, d_done, err}); end
        checks++; if ({if_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata got %0h/%0h exp 0", if_rdata, d_rdata); end
        checks++; if ({if_stall, d_stall} !== 2'b00) begin errors++; $display("FAIL rst_stall got %b exp 00", {if_stall, d_stall}); end
        rst = 1'b0; #1;
        checks++; if ({if_stall, d_stall, bus.m_req_o} !== 3'b110) begin errors++; $display("FAIL rst_release got %b exp 110", {if_stall, d_stall, bus.m_req_o}); end
        step();
        if_req = 1'b0;
        checks++; if ({bus.m_req_o, bus.m_addr_o} !== {1'b1, 32'h0000_2000}) begin errors++; $display("FAIL rst_first_grant got %0h/%0h exp 1/2000", bus.m_req_o, bus.m_addr_o); end
        bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'h1111_2222;
        step();
        bus.m_ack_i = 1'b0; d_req = 1'b0;
        checks++; if ({d_done, d_rdata} !== {1'b1, 32'h1111_2222}) begin errors++; $display("FAIL rst_first_done got %0h/%0h exp 1/11112222", d_done, d_rdata); end
        step();
    endtask

    task automatic test_if_read();
        if_req = 1'b1; if_addr = 32'h0001_0008; #1;
        checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL ifr_stall_c0 got %0h exp 1", if_stall); end
        step();
        checks++; if ({bus.m_req_o, bus.m_we_o, bus.m_addr_o, if_stall} !== {2'b10, 32'h0001_0008, 1'b1}) begin errors++; $display("FAIL ifr_c1 got %0h/%0h/%0h/%0h exp 1/0/10008/1", bus.m_req_o, bus.m_we_o, bus.m_addr_o, if_stall); end
        step();
        checks++; if ({bus.m_req_o, if_stall, if_done} !== 3'b110) begin errors++; $display("FAIL ifr_c2 got %b exp 110", {bus.m_req_o, if_stall, if_done}); end
        bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'h0050_0093;
        step();
        checks++; if ({if_done, if_rdata, bus.m_req_o, if_stall} !== {1'b1, 32'h0050_0093, 2'b00}) begin errors++; $display("FAIL ifr_c3 got %0h/%0h/%0h/%0h exp 1/500093/0/0", if_done, if_rdata, bus.m_req_o, if_stall); end
        bus.m_ack_i = 1'b0; if_req = 1'b0;
        step();
        checks++; if ({if_done, bus.m_req_o} !== 2'b00) begin errors++; $display("FAIL ifr_c4 got %b exp 00", {if_done, bus.m_req_o}); end
    endtask

    task automatic test_contention();
        logic [31:0] exp_addr;
        d_addr = 32'h0000_0200; if_addr = 32'h0000_0300; d_we = 1'b0;
        d_req = 1'b1; if_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_addr = (k % 2 == 0) ? 32'h0000_0200 : 32'h0000_0300;
            step();
            checks++; if ({bus.m_req_o, bus.m_addr_o} !== {1'b1, exp_addr}) begin errors++; $display("FAIL cont_grant%0d got %0h/%0h exp 1/%0h", k, bus.m_req_o, bus.m_addr_o, exp_addr); end
            bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'hC000_0000 + k;
            step();
            bus.m_ack_i = 1'b0;
            if (k % 2 == 0) begin
                checks++; if ({d_done, if_done, d_rdata, bus.m_req_o} !== {2'b10, 32'hC000_0000 + k, 1'b0}) begin errors++; $display("FAIL cont_done%0d got %0h/%0h/%0h/%0h", k, d_done, if_done, d_rdata, bus.m_req_o); end
            end else begin
                checks++; if ({d_done, if_done, if_rdata, bus.m_req_o} !== {2'b01, 32'hC000_0000 + k, 1'b0}) begin errors++; $display("FAIL cont_done%0d got %0h/%0h/%0h/%0h", k, d_done, if_done, if_rdata, bus.m_req_o); end
            end
        end
        d_req = 1'b0; if_req = 1'b0;
        step();
        checks++; if (bus.m_req_o !== 1'b0) begin errors++; $display("FAIL cont_quiet got %0h exp 0", bus.m_req_o); end
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'h0000_0020;
        step();
        checks++; if ({bus.m_req_o, bus.m_addr_o} !== {1'b1, 32'h0000_0020}) begin errors++; $display("FAIL fl_grant got %0h/%0h exp 1/20", bus.m_req_o, bus.m_addr_o); end
        flush = 1'b1; d_req = 1'b1; d_addr = 32'h0000_0400;
        step();
        flush = 1'b0; if_req = 1'b0;
        bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'hAAAA_5555;
        step();
        bus.m_ack_i = 1'b0;
        checks++; if ({if_done, if_rdata, bus.m_req_o} !== {1'b0, 32'hC000_0003, 1'b0}) begin errors++; $display("FAIL fl_discard got %0h/%0h/%0h exp 0/c0000003/0", if_done, if_rdata, bus.m_req_o); end
        step();
        checks++; if ({bus.m_req_o, bus.m_addr_o} !== {1'b1, 32'h0000_0400}) begin errors++; $display("FAIL fl_next_d got %0h/%0h exp 1/400", bus.m_req_o, bus.m_addr_o); end
        bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'h0BAD_F00D;
        step();
        bus.m_ack_i = 1'b0; d_req = 1'b0;
        checks++; if ({d_done, d_rdata, if_done} !== {1'b1, 32'h0BAD_F00D, 1'b0}) begin errors++; $display("FAIL fl_d_done got %0h/%0h/%0h exp 1/badf00d/0", d_done, d_rdata, if_done); end
        step();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
        step();
        checks++; if ({bus.m_req_o, bus.m_we_o, bus.m_addr_o, bus.m_wdata_o} !== {2'b11, 32'h0000_0100, 32'hDEAD_BEEF}) begin errors++; $display("FAIL st_c1 got %0h/%0h/%0h/%0h", bus.m_req_o, bus.m_we_o, bus.m_addr_o, bus.m_wdata_o); end
        step();
        checks++; if ({bus.m_req_o, bus.m_we_o, bus.m_addr_o, bus.m_wdata_o, d_done} !== {2'b11, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0}) begin errors++; $display("FAIL st_hold got %0h/%0h/%0h/%0h/%0h", bus.m_req_o, bus.m_we_o, bus.m_addr_o, bus.m_wdata_o, d_done); end
        bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'hFFFF_FFFF;
        step();
        bus.m_ack_i = 1'b0; d_req = 1'b0; d_we = 1'b0;
        checks++; if ({d_done, d_rdata, bus.m_req_o} !== {1'b1, 32'h0BAD_F00D, 1'b0}) begin errors++; $display("FAIL st_done got %0h/%0h/%0h exp 1/badf00d/0", d_done, d_rdata, bus.m_req_o); end
        step();
        bus.m_ack_i = 1'b1; bus.m_rdata_i = 32'h1234_5678;
        step();
        bus.m_ack_i = 1'b0;
        checks++; if ({if_done, d_done, bus.m_req_o, d_rdata, if_rdata} !== {3'b000, 32'h0BAD_F00D, 32'hC000_0003}) begin errors++; $display("FAIL idle_ack got %0h/%0h/%0h/%0h/%0h", if_done, d_done, bus.m_req_o, d_rdata, if_rdata); end
    endtask

    task automatic test_timeout();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++; if ({bus.m_req_o, err, d_done} !== 3'b100) begin errors++; $display("FAIL to_busy%0d got %b exp 100", c, {bus.m_req_o, err, d_done}); end
        end
        step();
        d_req = 1'b0;
        checks++; if ({bus.m_req_o, err, d_done, d_rdata} !== {3'b011, 32'h0}) begin errors++; $display("FAIL to_abort got %0h/%0h/%0h/%0h exp 0/1/1/0", bus.m_req_o, err, d_done, d_rdata); end
        step();
        checks++; if ({err, d_done, bus.m_req_o} !== 3'b100) begin errors++; $display("FAIL to_sticky got %b exp 100", {err, d_done, bus.m_req_o}); end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_contention();
        test_flush();
        test_store();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported instruction/data memory between the CPU's fetch stage (IF) and memory stage (MEM). It serializes their requests onto a registered request/acknowledge memory port and returns read data to each requester. It drives per-port stall lines into the pipeline hazard logic and supports cancelling fetches on branch redirect. A watchdog aborts hung memory transactions so the pipeline cannot deadlock.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 16, max cycles in a BUSY state before abort (≥2)

- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- if_req_i  in  1  fetch request; held until if_done_o
- if_addr_i  in  ADDR_W  fetch address; stable while if_req_i
- if_rdata_o  out  DATA_W  fetched word, registered
- if_done_o  out  1  one-cycle completion pulse
- if_stall_o  out  1  if_req_i & ~if_done_o & ~rst_i
- d_req_i  in  1  data request; held until d_done_o
- d_we_i  in  1  1 = store
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_rdata_o  out  DATA_W  load data, registered
- d_done_o  out  1  one-cycle completion pulse
- d_stall_o  out  1  d_req_i & ~d_done_o & ~rst_i
- flush_i  in  1  cancel the current and pending fetch (branch taken)
- m_req_o  out  1  memory request, registered
- m_we_o  out  1  memory write enable
- m_addr_o  out  ADDR_W  memory address
- m_wdata_o  out  DATA_W  memory write data
- m_rdata_i  in  DATA_W  read data; valid with m_ack_i
- m_ack_i  in  1  one-cycle completion from memory
- err_o  out  1  sticky timeout flag

## Operation
- FSM states:
  - IDLE: no memory transaction outstanding.
  - BUSY_IF: fetch transaction outstanding.
  - BUSY_D: data transaction outstanding.
- Reset: state IDLE, last_grant = IF, discard = 0, wait counter = 0, err_o = 0. All other registered outputs are 0.
- IDLE arbitration each cycle. A port is eligible when its req is high and its done pulse is not high this cycle.
  - IF additionally needs flush_i low to be eligible.
  - Only one port eligible: grant it.
  - Both eligible: grant D unless last_grant == D, then grant IF.
  - On grant: latch addr/we/wdata into m_*_o, set m_req_o = 1, update last_grant, clear the wait counter.
- BUSY: m_req_o and m_* stay stable until m_ack_i.
  - On m_ack_i: drop m_req_o and return to IDLE.
  - For a read, capture m_rdata_i into the granted port's rdata_o. For a store, rdata_o is unchanged.
  - Pulse that port's done_o next cycle.
- m_ack_i is ignored while in IDLE.
- flush_i while in BUSY_IF sets discard. On ack with discard set:
  - if_done_o is not pulsed and if_rdata_o is unchanged.
  - discard is cleared.
- flush_i in the same cycle as ack in BUSY_IF counts as discard.
- Watchdog: the wait counter increments each BUSY cycle without ack. Reaching MAX_WAIT causes an abort:
  - m_req_o drops, state returns to IDLE, err_o is set sticky.
  - The port's done pulses with rdata_o = 0, unless the transaction is a discarded IF.
- rst_i mid-transaction aborts immediately. There is no done pulse, and m_req_o is 0 next cycle.

## Timing
- Grant in cycle t → m_req_o high from t+1.
- Ack in cycle k → done_o and rdata_o valid in k+1, with m_req_o low in k+1.
- Earliest next grant is in cycle k+1, so the earliest next m_req_o is k+2.
- Minimum turnaround is 3 cycles per transaction with a 1-cycle memory.
- Stall outputs are combinational from req/done. They fall in the done cycle.

## Test plan
- Reset: assert rst_i with both reqs high → all outputs 0, including both stalls. Release → D granted first and m_req_o high one cycle later.
- IF read:
  - Stimulus: if_addr_i 0x10008 requested at cycle 0; ack at cycle 2 with 0x00500093.
  - Required: m_req_o high cycles 1–2; if_done_o and if_rdata_o = 0x00500093 in cycle 3; if_stall_o high cycles 0–2.
- Contention: both ports request continuously → grant order D, IF, D, IF. No port is re-granted while its done is high.
- Flush:
  - Stimulus: flush_i pulsed during BUSY_IF with address 0x20, then ack with 0xAAAA5555.
  - Required: no if_done_o; if_rdata_o keeps its prior value; a pending D request is granted next.
- Timeout: with MAX_WAIT = 4, a D read is never acked → after 4 BUSY cycles err_o = 1 (stays 1), d_done_o pulses with d_rdata_o = 0, and m_req_o = 0.
- Store: d_we_i = 1, address 0x100, data 0xDEADBEEF → m_we_o = 1, m_addr_o = 0x100, m_wdata_o = 0xDEADBEEF until ack; d_done_o pulses; d_rdata_o unchanged.
